vape_metadata_regs: RTL and testbench



---
 rtl/vape_pkg.sv | 20 ++
 rtl/vape_range_chk.sv | 13 +
 rtl/vape_metadata_regs.sv | 166 ++++++++++++++++
 tb/tb_vape_metadata_regs.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vape_pkg.sv
// Shared encodings for the VAPE metadata register block: FSM states,
// word offsets within the block and EXEC register bit positions.
package vape_pkg;

  typedef enum logic [1:0] {
    VAPE_IDLE = 2'd0,
    VAPE_RUN  = 2'd1,
    VAPE_DONE = 2'd2
  } vape_state_e;

  localparam logic [3:0] OFF_ER_MIN = 4'h0;
  localparam logic [3:0] OFF_ER_MAX = 4'h2;
  localparam logic [3:0] OFF_OR_MIN = 4'h4;
  localparam logic [3:0] OFF_OR_MAX = 4'h6;
  localparam logic [3:0] OFF_EXEC   = 4'h8;

  localparam int unsigned EXEC_BIT_FLAG = 0;
  localparam int unsigned EXEC_BIT_LOCK = 1;

endpackage

// File: rtl/vape_range_chk.sv
// Combinational inclusive range comparator: in_range_o = lo_i <= x_i <= hi_i.
module vape_range_chk #(
  parameter int unsigned Width = 16
) (
  input  logic [Width-1:0] lo_i,
  input  logic [Width-1:0] hi_i,
  input  logic [Width-1:0] x_i,
  output logic             in_range_o
);

  assign in_range_o = (x_i >= lo_i) && (x_i <= hi_i);

endmodule

// File: rtl/vape_metadata_regs.sv
// ER/OR bound registers for the output-protection monitor, locked while the
// executable region runs, with a sticky EXEC flag set on a clean ER exit.
module vape_metadata_regs
  import vape_pkg::*;
#(
  parameter logic [15:0] META_BASE     = 16'h0140,
  parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic [15:0] data_addr,
  input  logic        data_en,
  input  logic        data_wr,
  input  logic [15:0] data_wdata,
  output logic [15:0] data_rdata,
  input  logic [15:0] dma_addr,
  input  logic        dma_en,
  input  logic        exec_in,
  output logic [15:0] ER_min,
  output logic [15:0] ER_max,
  output logic [15:0] OR_min,
  output logic [15:0] OR_max,
  output logic        exec_flag,
  output logic        meta_lock,
  output logic        meta_viol
);

  localparam logic [15:0] BlkHi = META_BASE + 16'd9;

  vape_state_e state_q;
  logic [15:0] er_min_q, er_max_q, or_min_q, or_max_q;
  logic [15:0] rdata_q;
  logic        exec_flag_q;
  logic        meta_viol_q;

  logic        cpu_hit, dma_hit, in_er;
  logic [3:0]  cpu_off;
  logic        wr_cpu, wr_exec, wr_bound, rd_cpu;
  logic        illegal, cfg_ok;
  logic [15:0] rd_val;

  vape_range_chk #(.Width(16)) u_cpu_hit (
    .lo_i       (META_BASE),
    .hi_i       (BlkHi),
    .x_i        (data_addr),
    .in_range_o (cpu_hit)
  );

  vape_range_chk #(.Width(16)) u_dma_hit (
    .lo_i       (META_BASE),
    .hi_i       (BlkHi),
    .x_i        (dma_addr),
    .in_range_o (dma_hit)
  );

  vape_range_chk #(.Width(16)) u_in_er (
    .lo_i       (er_min_q),
    .hi_i       (er_max_q),
    .x_i        (pc),
    .in_range_o (in_er)
  );

  // Word offset within the block; the address LSB is dropped.
  assign cpu_off = 4'((data_addr - META_BASE) & 16'h000E);

  always_comb begin
    wr_cpu   = data_en && data_wr && cpu_hit;
    rd_cpu   = data_en && !data_wr;
    wr_exec  = wr_cpu && (cpu_off == OFF_EXEC);
    wr_bound = wr_cpu && !wr_exec;
    illegal  = (wr_bound && (state_q != VAPE_IDLE)) || wr_exec || (dma_en && dma_hit);
    cfg_ok   = (er_min_q < er_max_q) && (or_min_q < or_max_q);
  end

  always_comb begin
    rd_val = 16'h0000;
    if (cpu_hit) begin
      case (cpu_off)
        OFF_ER_MIN: rd_val = er_min_q;
        OFF_ER_MAX: rd_val = er_max_q;
        OFF_OR_MIN: rd_val = or_min_q;
        OFF_OR_MAX: rd_val = or_max_q;
        OFF_EXEC: begin
          rd_val[EXEC_BIT_FLAG] = exec_flag_q;
          rd_val[EXEC_BIT_LOCK] = (state_q != VAPE_IDLE);
        end
        default: rd_val = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= VAPE_IDLE;
      er_min_q    <= 16'h0000;
      er_max_q    <= 16'h0000;
      or_min_q    <= 16'h0000;
      or_max_q    <= 16'h0000;
      rdata_q     <= 16'h0000;
      exec_flag_q <= 1'b0;
      meta_viol_q <= 1'b0;
    end else begin
      meta_viol_q <= 1'b0;
      if (rd_cpu) begin
        rdata_q <= rd_val;
      end
      if (pc == RESET_HANDLER) begin
        state_q     <= VAPE_IDLE;
        exec_flag_q <= 1'b0;
      end else if (illegal) begin
        meta_viol_q <= 1'b1;
        state_q     <= VAPE_IDLE;
        exec_flag_q <= 1'b0;
      end else begin
        unique case (state_q)
          VAPE_IDLE: begin
            // A legal write defers RUN entry so the new ER_min is used next cycle.
            if (wr_bound) begin
              case (cpu_off)
                OFF_ER_MIN: er_min_q <= data_wdata;
                OFF_ER_MAX: er_max_q <= data_wdata;
                OFF_OR_MIN: or_min_q <= data_wdata;
                OFF_OR_MAX: or_max_q <= data_wdata;
                default: ;
              endcase
            end else if ((pc == er_min_q) && cfg_ok) begin
              state_q <= VAPE_RUN;
            end
          end
          VAPE_RUN: begin
            if (!exec_in || !in_er) begin
              state_q <= VAPE_IDLE;
            end else if (pc == er_max_q) begin
              state_q     <= VAPE_DONE;
              exec_flag_q <= 1'b1;
            end
          end
          VAPE_DONE: begin
            if (!exec_in) begin
              state_q     <= VAPE_IDLE;
              exec_flag_q <= 1'b0;
            end else if (pc == er_min_q) begin
              state_q     <= VAPE_RUN;
              exec_flag_q <= 1'b0;
            end
          end
          default: begin
            state_q     <= VAPE_IDLE;
            exec_flag_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ER_min     = er_min_q;
  assign ER_max     = er_max_q;
  assign OR_min     = or_min_q;
  assign OR_max     = or_max_q;
  assign data_rdata = rdata_q;
  assign exec_flag  = exec_flag_q;
  assign meta_viol  = meta_viol_q;
  assign meta_lock  = (state_q != VAPE_IDLE);

endmodule

// File: tb/tb_vape_metadata_regs.sv
// Directed bench for vape_metadata_regs: bound programming, lock/attest flow,
// violations, read path and reset behaviour.
module tb_vape_metadata_regs;

  localparam logic [15:0] Base = 16'h0140;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic [15:0] data_addr;
  logic        data_en;
  logic        data_wr;
  logic [15:0] data_wdata;
  logic [15:0] data_rdata;
  logic [15:0] dma_addr;
  logic        dma_en;
  logic        exec_in;
  logic [15:0] er_min, er_max, or_min, or_max;
  logic        exec_flag, meta_lock, meta_viol;

  int checks = 0;
  int errors = 0;

  vape_metadata_regs #(
    .META_BASE     (16'h0140),
    .RESET_HANDLER (16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .data_addr  (data_addr),
    .data_en    (data_en),
    .data_wr    (data_wr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .dma_addr   (dma_addr),
    .dma_en     (dma_en),
    .exec_in    (exec_in),
    .ER_min     (er_min),
    .ER_max     (er_max),
    .OR_min     (or_min),
    .OR_max     (or_max),
    .exec_flag  (exec_flag),
    .meta_lock  (meta_lock),
    .meta_viol  (meta_viol)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [15:0] off, input logic [15:0] val);
    data_addr  = Base + off;
    data_wdata = val;
    data_wr    = 1'b1;
    data_en    = 1'b1;
    step();
    data_en    = 1'b0;
    data_wr    = 1'b0;
  endtask

  task automatic cpu_rd_addr(input logic [15:0] addr);
    data_addr = addr;
    data_wr   = 1'b0;
    data_en   = 1'b1;
    step();
    data_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc = 16'h1234; data_addr = 16'h0000; data_en = 1'b0; data_wr = 1'b0;
    data_wdata = 16'h0000; dma_addr = 16'h0000; dma_en = 1'b0; exec_in = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_er_min", er_min, 16'h0000);
    check("rst_er_max", er_max, 16'h0000);
    check("rst_or_min", or_min, 16'h0000);
    check("rst_or_max", or_max, 16'h0000);
    check("rst_rdata", data_rdata, 16'h0000);
    check("rst_flag", {15'd0, exec_flag}, 16'h0000);
    check("rst_lock", {15'd0, meta_lock}, 16'h0000);
    check("rst_viol", {15'd0, meta_viol}, 16'h0000);

    cpu_rd_addr(Base + 16'h8);
    check("rd_exec_reset", data_rdata, 16'h0000);
    pc = 16'h0000;
    step();
    check("idle_cfg_bad", {15'd0, meta_lock}, 16'h0000);

    // Program bounds
    pc = 16'h1234;
    cpu_wr(16'h0, 16'hE000);
    cpu_wr(16'h2, 16'hE0FE);
    cpu_wr(16'h4, 16'h0400);
    cpu_wr(16'h6, 16'h041E);
    check("prog_er_min", er_min, 16'hE000);
    check("prog_er_max", er_max, 16'hE0FE);
    check("prog_or_min", or_min, 16'h0400);
    check("prog_or_max", or_max, 16'h041E);
    cpu_rd_addr(Base + 16'h4);
    check("rd_or_min", data_rdata, 16'h0400);

    // Clean run through ER
    exec_in = 1'b1;
    pc = 16'hE000;
    step();
    check("run_entry_lock", {15'd0, meta_lock}, 16'h0001);
    check("run_entry_flag", {15'd0, exec_flag}, 16'h0000);
    for (int a = 16'hE001; a < 16'hE0FE; a++) begin
      pc = 16'(a);
      step();
    end
    check("sweep_lock", {15'd0, meta_lock}, 16'h0001);
    check("sweep_flag_pre", {15'd0, exec_flag}, 16'h0000);
    pc = 16'hE0FE;
    step();
    check("done_flag", {15'd0, exec_flag}, 16'h0001);
    cpu_rd_addr(Base + 16'h8);
    check("rd_exec_done", data_rdata, 16'h0003);

    // Re-execution, then illegal write in RUN
    pc = 16'hE000;
    step();
    check("reexec_lock", {15'd0, meta_lock}, 16'h0001);
    check("reexec_flag", {15'd0, exec_flag}, 16'h0000);
    pc = 16'hE010;
    step();
    cpu_wr(16'h4, 16'h0500);
    check("runwr_viol", {15'd0, meta_viol}, 16'h0001);
    check("runwr_lock", {15'd0, meta_lock}, 16'h0000);
    check("runwr_or_min", or_min, 16'h0400);
    check("runwr_flag", {15'd0, exec_flag}, 16'h0000);
    step();
    check("runwr_viol_pulse", {15'd0, meta_viol}, 16'h0000);

    // Abort by leaving ER
    pc = 16'hE000;
    step();
    check("abort_pre_lock", {15'd0, meta_lock}, 16'h0001);
    pc = 16'hC000;
    step();
    check("abort_lock", {15'd0, meta_lock}, 16'h0000);
    check("abort_flag", {15'd0, exec_flag}, 16'h0000);

    // DMA into the block while DONE
    pc = 16'hE000;
    step();
    pc = 16'hE0FE;
    step();
    check("dma_pre_flag", {15'd0, exec_flag}, 16'h0001);
    dma_addr = Base + 16'h2;
    dma_en = 1'b1;
    step();
    dma_en = 1'b0;
    check("dma_viol", {15'd0, meta_viol}, 16'h0001);
    check("dma_flag", {15'd0, exec_flag}, 16'h0000);
    check("dma_lock", {15'd0, meta_lock}, 16'h0000);
    step();
    check("dma_viol_pulse", {15'd0, meta_viol}, 16'h0000);

    // exec_in drop while DONE
    pc = 16'hE000;
    step();
    pc = 16'hE0FE;
    step();
    check("drop_pre_flag", {15'd0, exec_flag}, 16'h0001);
    exec_in = 1'b0;
    step();
    check("drop_flag", {15'd0, exec_flag}, 16'h0000);
    check("drop_lock", {15'd0, meta_lock}, 16'h0000);
    exec_in = 1'b1;

    // Write coinciding with pc == ER_min defers entry by one cycle
    pc = 16'hE000;
    cpu_wr(16'h0, 16'hE000);
    check("coll_lock_defer", {15'd0, meta_lock}, 16'h0000);
    check("coll_er_min", er_min, 16'hE000);
    step();
    check("coll_lock_next", {15'd0, meta_lock}, 16'h0001);

    // Write to EXEC is illegal even when IDLE
    exec_in = 1'b0;
    step();
    exec_in = 1'b1;
    pc = 16'h1234;
    cpu_wr(16'h8, 16'hFFFF);
    check("execwr_viol", {15'd0, meta_viol}, 16'h0001);
    check("execwr_er_min", er_min, 16'hE000);

    // Read path: hold, LSB ignored, out-of-block
    cpu_rd_addr(Base + 16'h2);
    check("rd_er_max", data_rdata, 16'hE0FE);
    step();
    check("rd_hold", data_rdata, 16'hE0FE);
    cpu_rd_addr(Base + 16'h5);
    check("rd_lsb_ign", data_rdata, 16'h0400);
    cpu_rd_addr(16'h0200);
    check("rd_out_blk", data_rdata, 16'h0000);

    // pc at the reset handler clears DONE without a violation
    pc = 16'hE000;
    step();
    pc = 16'hE0FE;
    step();
    check("rh_pre_flag", {15'd0, exec_flag}, 16'h0001);
    pc = 16'h0000;
    step();
    check("rh_flag", {15'd0, exec_flag}, 16'h0000);
    check("rh_lock", {15'd0, meta_lock}, 16'h0000);
    check("rh_viol", {15'd0, meta_viol}, 16'h0000);
    check("rh_bounds", er_max, 16'hE0FE);

    // Reset mid-RUN
    pc = 16'hE000;
    step();
    check("rstrun_pre_lock", {15'd0, meta_lock}, 16'h0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstrun_lock", {15'd0, meta_lock}, 16'h0000);
    check("rstrun_er_min", er_min, 16'h0000);
    check("rstrun_or_max", or_max, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
